byte_fifo: RTL

- Elastic byte buffer directly downstream of the byte/nibble packer stage.
- Captures each packed byte qualified by the packer's enable strobe. The packer has no backpressure, so this block absorbs bursts and flags any drops.
- Presents bytes to the consumer through a first-word-fall-through valid/ready interface.
- Also exports occupancy, full/empty/almost-full status and a saturating drop counter.

---
 rtl/byte_fifo_if.sv | 27 ++
 rtl/byte_fifo.sv | 106 ++++++++++
 2 files changed

// File: rtl/byte_fifo_if.sv
// Byte stream handshake between the packer-side producer and the FWFT consumer.
// The FIFO sits on the slave side. The environment driving it sits on the master side.
interface byte_fifo_if #(
    parameter int DW = 8
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_data,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/byte_fifo.sv
// Elastic first-word-fall-through byte buffer behind the packer stage.
// The packer has no backpressure, so writes arriving while the buffer is full are dropped and counted.
module byte_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic          clk,
    input  logic          reset,
    byte_fifo_if.slave    bus,
    input  logic          flush,
    input  logic          clr_ovf,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] last_rd;
    logic [DW-1:0] rd_data_c;

    logic pop_req;
    logic push_req;
    logic drop;

    // Status comes from the registered count only, so there is no combinational path from the inputs.
    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CW'(AFULL_LVL));

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign pop_req  = !empty && bus.rd_ready;
    assign push_req = bus.wr_en && (!full || pop_req);
    assign drop     = bus.wr_en && !push_req && !flush;

    // NOTE: state is updated with non-blocking assignments, so every process sees the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_req) wr_ptr <= wr_ptr + AW'(1);
            if (pop_req)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_req, pop_req})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: only entry 0 is reset. The other entries are never read before they are written,
    // so the array can stay plain storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
        end else if (push_req && !flush) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Remembers the byte last handed to the consumer, so rd_data holds it while the buffer is empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_rd <= '0;
        end else if (pop_req && !flush) begin
            last_rd <= mem[rd_ptr];
        end
    end

    // When a drop and a clear land on the same edge, the drop wins and counting restarts at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    // NOTE: the default assignment comes first, so no latch can be inferred from this block.
    always_comb begin
        rd_data_c = last_rd;
        if (!empty) rd_data_c = mem[rd_ptr];
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_valid = !empty;
endmodule
